// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and the tx FIFO pop-FSM state type
package uart_pkg;
  localparam int DATA_W       = 8;
  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BUSY_TIMEOUT = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BSY, WAIT_IDL} pop_state_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: 2**AW x DATA_W storage, one synchronous write port, one asynchronous read port
//   clk          write clock
//   we/waddr/wdata  write strobe, address, data
//   raddr/rdata  combinational read
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO from uart_rx to uart_tx with start-pulse/busy launch handshake
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   wr_en, wr_data       byte strobe and data from the receiver
//   tx_busy              transmitter busy for the whole frame
//   tx_start, tx_byte    one-cycle launch pulse and the byte it carries
//   full, empty, count   registered occupancy
//   overflow             sticky dropped-write flag
//   drop_cnt             saturating dropped-write counter, only with UART_TX_FIFO_DROPCNT_EN
module uart_tx_fifo #(
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int AW     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_byte,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
`ifdef UART_TX_FIFO_DROPCNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);
  import uart_pkg::*;
  localparam int DEPTH = 2**AW;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0] count_nxt;
  logic [2:0] tmr, tmr_nxt;
  logic wr_ok, pop, ld;
  pop_state_t state, state_nxt;
  uart_fifo_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk   (sys_clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
  // full is the pre-edge flag, so a write racing a pop out of a full FIFO is dropped
  assign wr_ok     = wr_en & ~full;
  assign pop       = state == LAUNCH;
  // tx_byte is captured on entry to LAUNCH so it is already valid while tx_start is high
  assign ld        = state == IDLE & ~empty & ~tx_busy;
  assign tx_start  = pop;
  assign count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
  always_comb begin
    state_nxt = state;
    tmr_nxt   = '0;
    case (state)
      IDLE:     state_nxt = ld ? LAUNCH : IDLE;
      LAUNCH:   state_nxt = WAIT_BSY;
      WAIT_BSY: begin
        state_nxt = tx_busy ? WAIT_IDL : tmr == 3'(BUSY_TIMEOUT - 1) ? IDLE : WAIT_BSY;
        tmr_nxt   = tmr + 3'd1;
      end
      WAIT_IDL: state_nxt = tx_busy ? WAIT_IDL : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state    <= IDLE;
      tmr      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      tx_byte  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      wr_ptr   <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count    <= count_nxt;
      full     <= count_nxt == (AW+1)'(DEPTH);
      empty    <= count_nxt == '0;
      tx_byte  <= ld ? rd_data : tx_byte;
      overflow <= overflow | (wr_en & full);
    end
`ifdef UART_TX_FIFO_DROPCNT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) drop_cnt <= '0;
    else if (wr_en && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
endmodule
